// File: rtl/mul_arb_pkg.sv
// Shared constants and helpers for the shared signed multiplier arbiter.
//   A_W / B_W  : operand widths (signed multiplicand / multiplier)
//   P_W        : exact product width
//   OUT_W      : response width, sign-extended from P_W
//   LAT_MAX / NREQ_MAX : upper bounds of the block parameters
package mul_arb_pkg;

    localparam int A_W      = 16;
    localparam int B_W      = 8;
    localparam int P_W      = 24;
    localparam int OUT_W    = 32;
    localparam int LAT_MAX  = 4;
    localparam int NREQ_MAX = 4;

    // Sign-extend an exact product to the response width.
    function automatic logic [OUT_W-1:0] sext_prod(input logic [P_W-1:0] p);
        return {{(OUT_W-P_W){p[P_W-1]}}, p};
    endfunction

endpackage

// File: rtl/mul_arbiter_rr_arbiter.sv
// Round-robin arbiter with a registered "last granted" pointer.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset; pointer goes to NREQ-1
//   req    : per-requester request lines
//   en     : grant enable (low blocks every grant)
//   update : strobe; a grant was accepted this cycle, move the pointer
//   grant  : one-hot or zero, combinational
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic            update,
    output logic [NREQ-1:0] grant
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] idx;
    logic             found;

    // Search starts one past the last winner and wraps, so the most
    // recently served requester has the lowest priority.
    always_comb begin
        grant   = '0;
        win_idx = last_q;
        idx     = '0;
        found   = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = IDX_W'((int'(last_q) + off) % NREQ);
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win_idx    = idx;
            end
        end
    end

    always_comb begin
        last_d = update ? win_idx : last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= IDX_W'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one signed 16x8 multiplier between NREQ requesters.
//   clk_in    : clock, rising edge
//   rst_p     : asynchronous active-high reset
//   hold      : blocks new grants; in-flight products still drain
//   req_valid : per-requester valid
//   req_a     : packed signed 16-bit multiplicands, requester i at [16i+15:16i]
//   req_b     : packed signed 8-bit multipliers, requester i at [8i+7:8i]
//   req_ready : combinational one-hot grant
//   rsp_valid : registered one-hot owner of rsp_data
//   rsp_data  : registered product sign-extended to 32 bits, held when idle
//   busy      : high while any stage holds a valid operation
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int LAT  = 1
) (
    input  logic                clk_in,
    input  logic                rst_p,
    input  logic                hold,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [A_W*NREQ-1:0] req_a,
    input  logic [B_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [OUT_W-1:0]    rsp_data,
    output logic                busy
);

    logic [NREQ-1:0]  grant;
    logic             fire;
    logic [A_W-1:0]   a_arr [NREQ];
    logic [B_W-1:0]   b_arr [NREQ];
    logic [A_W-1:0]   sel_a;
    logic [B_W-1:0]   sel_b;
    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;
    logic signed [P_W-1:0] prod;

    // Pipeline stages: one-hot owner tag (zero means empty) plus product.
    logic [NREQ-1:0]  own_q  [LAT];
    logic [NREQ-1:0]  own_d  [LAT];
    logic [P_W-1:0]   prod_q [LAT];
    logic [P_W-1:0]   prod_d [LAT];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*A_W +: A_W];
            assign b_arr[gi] = req_b[gi*B_W +: B_W];
        end
    endgenerate

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk    (clk_in),
        .rst    (rst_p),
        .req    (req_valid),
        .en     (~hold),
        .update (fire),
        .grant  (grant)
    );

    // The arbiter only grants valid requesters, so any grant is a transfer.
    assign req_ready = grant;
    assign fire      = |grant;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = a_arr[i];
                sel_b = b_arr[i];
            end
        end
    end

    // Operands are widened to the product width so the multiply is exact.
    assign a_ext = {{(P_W-A_W){sel_a[A_W-1]}}, sel_a};
    assign b_ext = {{(P_W-B_W){sel_b[B_W-1]}}, sel_b};
    assign prod = a_ext * b_ext;

    // Product registers only load when a valid op moves in, so the last
    // stage keeps its data while rsp_valid is low.
    always_comb begin
        own_d[0]  = fire ? grant : '0;
        prod_d[0] = fire ? prod : prod_q[0];
        for (int s = 1; s < LAT; s++) begin
            own_d[s]  = own_q[s-1];
            prod_d[s] = (|own_q[s-1]) ? prod_q[s-1] : prod_q[s];
        end
    end

    always_ff @(posedge clk_in or posedge rst_p) begin
        if (rst_p) begin
            for (int s = 0; s < LAT; s++) begin
                own_q[s]  <= '0;
                prod_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < LAT; s++) begin
                own_q[s]  <= own_d[s];
                prod_q[s] <= prod_d[s];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < LAT; s++) begin
            busy = busy | (|own_q[s]);
        end
    end

    assign rsp_valid = own_q[LAT-1];
    assign rsp_data  = sext_prod(prod_q[LAT-1]);

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;

    logic clk = 1'b0;
    logic rst_p;
    always #5 clk = ~clk;

    // d1: NREQ=2 LAT=1
    logic h1; logic [1:0] v1; logic [31:0] a1; logic [15:0] b1;
    logic [1:0] rdy1, rv1; logic [31:0] rd1; logic bz1;
    // d3: NREQ=2 LAT=3
    logic h3; logic [1:0] v3; logic [31:0] a3; logic [15:0] b3;
    logic [1:0] rdy3, rv3; logic [31:0] rd3; logic bz3;
    // d4: NREQ=2 LAT=4
    logic h4; logic [1:0] v4; logic [31:0] a4; logic [15:0] b4;
    logic [1:0] rdy4, rv4; logic [31:0] rd4; logic bz4;
    // dn: NREQ=3 LAT=2
    logic hn; logic [2:0] vn; logic [47:0] an; logic [23:0] bn;
    logic [2:0] rdyn, rvn; logic [31:0] rdn; logic bzn;

    mul_arbiter #(.NREQ(2), .LAT(1)) u_d1 (
        .clk_in(clk), .rst_p(rst_p), .hold(h1), .req_valid(v1), .req_a(a1), .req_b(b1),
        .req_ready(rdy1), .rsp_valid(rv1), .rsp_data(rd1), .busy(bz1));
    mul_arbiter #(.NREQ(2), .LAT(3)) u_d3 (
        .clk_in(clk), .rst_p(rst_p), .hold(h3), .req_valid(v3), .req_a(a3), .req_b(b3),
        .req_ready(rdy3), .rsp_valid(rv3), .rsp_data(rd3), .busy(bz3));
    mul_arbiter #(.NREQ(2), .LAT(4)) u_d4 (
        .clk_in(clk), .rst_p(rst_p), .hold(h4), .req_valid(v4), .req_a(a4), .req_b(b4),
        .req_ready(rdy4), .rsp_valid(rv4), .rsp_data(rd4), .busy(bz4));
    mul_arbiter #(.NREQ(3), .LAT(2)) u_dn (
        .clk_in(clk), .rst_p(rst_p), .hold(hn), .req_valid(vn), .req_a(an), .req_b(bn),
        .req_ready(rdyn), .rsp_valid(rvn), .rsp_data(rdn), .busy(bzn));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Extreme operand table: requester, a, b, expected response.
    int          ex_q [4] = '{0, 0, 0, 1};
    logic [15:0] ex_a [4] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h7FFF};
    logic [7:0]  ex_b [4] = '{8'h80, 8'h7F, 8'h80, 8'h7F};
    logic [31:0] ex_r [4] = '{32'h0040_0000, 32'h003F_7F81, 32'h0000_0000, 32'h003F_7F81};

    // Lone requester table for the 3-requester instance.
    logic [15:0] ln_a [4] = '{16'h0001, 16'hFFFF, 16'h1234, 16'h8000};
    logic [7:0]  ln_b [4] = '{8'h7F, 8'h80, 8'h10, 8'h01};
    logic [31:0] ln_r [4] = '{32'h0000_007F, 32'h0000_0080, 32'h0001_2340, 32'hFFFF_8000};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] ev;
        rst_p = 1'b1;
        h1 = 0; v1 = '0; a1 = '0; b1 = '0;
        h3 = 0; v3 = '0; a3 = '0; b3 = '0;
        h4 = 0; v4 = '0; a4 = '0; b4 = '0;
        hn = 0; vn = '0; an = '0; bn = '0;
        tick();
        tick();
        chk("rst_rv", 32'(rv1), 32'h0);
        chk("rst_rd", rd1, 32'h0);
        chk("rst_busy", 32'(bz1), 32'h0);
        rst_p = 1'b0;
        tick();

        // Single request, LAT=1
        v1 = 2'b01; a1 = {16'h0000, 16'hFFFD}; b1 = {8'h00, 8'h05};
        #1;
        chk("single_rdy", 32'(rdy1), 32'h1);
        chk("single_busy_pre", 32'(bz1), 32'h0);
        tick();
        v1 = '0;
        chk("single_rv", 32'(rv1), 32'h1);
        chk("single_rd", rd1, 32'hFFFF_FFF1);
        chk("single_busy", 32'(bz1), 32'h1);
        tick();
        chk("single_rv_end", 32'(rv1), 32'h0);
        chk("single_busy_end", 32'(bz1), 32'h0);
        chk("single_rd_hold", rd1, 32'hFFFF_FFF1);

        // Extremes
        for (int i = 0; i < 4; i++) begin
            ev = 2'b01 << ex_q[i];
            v1 = ev; a1 = {2{ex_a[i]}}; b1 = {2{ex_b[i]}};
            #1;
            chk($sformatf("ext%0d_rdy", i), 32'(rdy1), 32'(ev));
            tick();
            v1 = '0;
            chk($sformatf("ext%0d_rv", i), 32'(rv1), 32'(ev));
            chk($sformatf("ext%0d_rd", i), rd1, ex_r[i]);
        end

        // Contention, LAT=3: req0 3*2=6, req1 -4*7=-28
        a3 = {16'hFFFC, 16'h0003}; b3 = {8'h07, 8'h02};
        for (int c = 0; c < 10; c++) begin
            v3 = (c < 6) ? 2'b11 : 2'b00;
            #1;
            ev = (c >= 6) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("cont%0d_rdy", c), 32'(rdy3), 32'(ev));
            tick();
            ev = (c >= 2 && c < 8) ? (((c - 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            chk($sformatf("cont%0d_rv", c), 32'(rv3), 32'(ev));
            if (ev != 2'b00)
                chk($sformatf("cont%0d_rd", c), rd3, (ev == 2'b01) ? 32'd6 : 32'hFFFF_FFE4);
        end

        // hold: last is 1 after contention
        v3 = 2'b11; h3 = 1'b0;
        #1;
        chk("hold_pre_rdy", 32'(rdy3), 32'h1);
        tick();
        h3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("hold%0d_rdy", i), 32'(rdy3), 32'h0);
            tick();
            chk($sformatf("hold%0d_rv", i), 32'(rv3), (i == 1) ? 32'h1 : 32'h0);
            if (i == 1) chk("hold_rd", rd3, 32'd6);
            chk($sformatf("hold%0d_busy", i), 32'(bz3), (i == 2) ? 32'h0 : 32'h1);
        end
        h3 = 1'b0;
        #1;
        chk("hold_rel_rdy", 32'(rdy3), 32'h2);
        tick();
        v3 = '0;
        tick();
        tick();
        chk("hold_rel_rv", 32'(rv3), 32'h2);
        chk("hold_rel_rd", rd3, 32'hFFFF_FFE4);
        tick();
        chk("hold_done_busy", 32'(bz3), 32'h0);

        // Reset mid-operation, LAT=4. First a completed op on req1: 5*5=25.
        v4 = 2'b10; a4 = {16'd5, 16'd0}; b4 = {8'd5, 8'd0};
        #1;
        chk("rstm_pre_rdy", 32'(rdy4), 32'h2);
        tick();
        v4 = '0;
        tick();
        tick();
        chk("rstm_pre_rv_early", 32'(rv4), 32'h0);
        tick();
        chk("rstm_pre_rv", 32'(rv4), 32'h2);
        chk("rstm_pre_rd", rd4, 32'd25);
        v4 = 2'b11; a4 = {16'd5, 16'd2}; b4 = {8'd5, 8'd3};
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("rstm_issue%0d_rdy", i), 32'(rdy4), (i % 2 == 0) ? 32'h1 : 32'h2);
            tick();
        end
        v4 = '0;
        chk("rstm_busy_before", 32'(bz4), 32'h1);
        #2;
        rst_p = 1'b1;
        #1;
        chk("rstm_rv", 32'(rv4), 32'h0);
        chk("rstm_rd", rd4, 32'h0);
        chk("rstm_busy", 32'(bz4), 32'h0);
        #2;
        rst_p = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rstm_stale%0d_rv", i), 32'(rv4), 32'h0);
        end
        v4 = 2'b11;
        #1;
        chk("rstm_post_rdy", 32'(rdy4), 32'h1);
        tick();
        v4 = '0;

        // Lone requester 2 of 3, LAT=2
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                vn = 3'b100;
                an = {ln_a[c], 32'h0};
                bn = {ln_b[c], 16'h0};
            end else begin
                vn = 3'b000;
            end
            #1;
            chk($sformatf("lone%0d_rdy", c), 32'(rdyn), (c < 4) ? 32'h4 : 32'h0);
            tick();
            if (c >= 1 && c <= 4) begin
                chk($sformatf("lone%0d_rv", c), 32'(rvn), 32'h4);
                chk($sformatf("lone%0d_rd", c), rdn, ln_r[c-1]);
            end else begin
                chk($sformatf("lone%0d_rv", c), 32'(rvn), 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
